// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a small return-address
// stack used by branch-to-subroutine and return redirects.
module fetch_stage #(
  parameter int PC_W      = 8,
  parameter int INSTR_W   = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               B,
  input  logic               L,
  input  logic               Ret,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic               ras_ovf,
  output logic               ras_udf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  ras_top;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_dec;
  logic [PTR_W-1:0] ras_ptr_inc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             redirect;
  logic             push;
  logic             pop;

  assign imem_addr   = pc;
  assign pc_inc      = pc + PC_W'(1);

  // A bubble in IF/ID can never redirect, so stale decode of a flushed slot is harmless.
  assign redirect    = B & if_id_valid & ~stall;
  assign pop         = redirect & Ret;
  assign push        = redirect & L & ~Ret;

  assign ras_ptr_dec = ras_ptr - PTR_W'(1);
  assign ras_ptr_inc = ras_ptr + PTR_W'(1);
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_top     = ras_empty ? '0 : ras_mem[ras_ptr_dec];
  assign target      = Ret ? ras_top : br_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      if_id_instr <= '0;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        // The word fetched on the wrong path this cycle is dropped; pc1 is left alone.
        pc          <= target;
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end else begin
        pc          <= pc_inc;
        if_id_instr <= imem_data;
        if_id_pc1   <= pc_inc;
        if_id_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      ras_ptr   <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_udf   <= 1'b0;
    end else if (pop) begin
      if (ras_empty) begin
        ras_udf <= 1'b1;
      end else begin
        ras_ptr   <= ras_ptr_dec;
        ras_count <= ras_count - CNT_W'(1);
      end
    end else if (push) begin
      // When full, the circular pointer lands on the oldest entry and overwrites it.
      ras_mem[ras_ptr] <= if_id_pc1;
      ras_ptr          <= ras_ptr_inc;
      if (ras_full) ras_ovf <= 1'b1;
      else          ras_count <= ras_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; instruction memory returns address ^ 0xA5.
module tb_fetch_stage;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       B;
  logic       L;
  logic       Ret;
  logic [7:0] br_target;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc1;
  logic       if_id_valid;
  logic       ras_ovf;
  logic       ras_udf;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage #(.PC_W(8), .INSTR_W(8), .RAS_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .B          (B),
    .L          (L),
    .Ret        (Ret),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .if_id_instr(if_id_instr),
    .if_id_pc1  (if_id_pc1),
    .if_id_valid(if_id_valid),
    .ras_ovf    (ras_ovf),
    .ras_udf    (ras_udf)
  );

  assign imem_data = imem_addr ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic l, input logic r,
                               input logic s, input logic [7:0] tgt);
    B = b; L = l; Ret = r; stall = s; br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [7:0] addr, input logic [7:0] instr,
                            input logic [7:0] pc1, input logic valid);
    checkOutput({tag, "_addr"},  32'(imem_addr),   32'(addr));
    checkOutput({tag, "_instr"}, 32'(if_id_instr), 32'(instr));
    checkOutput({tag, "_pc1"},   32'(if_id_pc1),   32'(pc1));
    checkOutput({tag, "_valid"}, 32'(if_id_valid), 32'(valid));
  endtask

  task automatic call_from(input logic [7:0] base);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, base);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 0, 8'hC0);
  endtask

  task automatic return_to(input string tag, input logic [7:0] expected);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 1, 0, 8'h77);
    checkOutput(tag, 32'(imem_addr), 32'(expected));
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; B = 1'b0; L = 1'b0; Ret = 1'b0; br_target = 8'h00;
    #2;
    check_ifid("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("reset_ovf", 32'(ras_ovf), 32'd0);
    checkOutput("reset_udf", 32'(ras_udf), 32'd0);
    #8 rst = 1'b1;

    $display("[TB] sequential fetch");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 8'h00);
      check_ifid("seq", 8'(i + 1), 8'(i) ^ 8'hA5, 8'(i + 1), 1'b1);
    end

    $display("[TB] taken branch");
    applyStimulus(1, 0, 0, 0, 8'h40);
    check_ifid("br_flush", 8'h40, 8'h00, 8'h06, 1'b0);
    applyStimulus(0, 0, 0, 0, 8'h00);
    check_ifid("br_after", 8'h41, 8'h40 ^ 8'hA5, 8'h41, 1'b1);

    $display("[TB] call and return");
    applyStimulus(1, 0, 0, 0, 8'h10);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("call_pc1", 32'(if_id_pc1), 32'h11);
    applyStimulus(1, 1, 0, 0, 8'h80);
    checkOutput("call_addr", 32'(imem_addr), 32'h80);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 1, 0, 8'h99);
    checkOutput("ret_addr", 32'(imem_addr), 32'h11);
    checkOutput("ret_ovf", 32'(ras_ovf), 32'd0);
    checkOutput("ret_udf", 32'(ras_udf), 32'd0);

    $display("[TB] stall");
    applyStimulus(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 8'h33);
      check_ifid("stall", 8'h12, 8'h11 ^ 8'hA5, 8'h12, 1'b1);
    end
    applyStimulus(1, 0, 0, 0, 8'h33);
    check_ifid("unstall", 8'h33, 8'h00, 8'h12, 1'b0);

    $display("[TB] nested calls");
    for (int k = 1; k <= 4; k++) call_from(8'(k * 16));
    checkOutput("ovf_before", 32'(ras_ovf), 32'd0);
    call_from(8'h50);
    checkOutput("ovf_after", 32'(ras_ovf), 32'd1);
    return_to("ret1", 8'h51);
    return_to("ret2", 8'h41);
    return_to("ret3", 8'h31);
    return_to("ret4", 8'h21);
    checkOutput("udf_before", 32'(ras_udf), 32'd0);
    return_to("ret5", 8'h00);
    checkOutput("udf_after", 32'(ras_udf), 32'd1);

    $display("[TB] pc wrap and async reset");
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'hFF);
    checkOutput("wrap_ff", 32'(imem_addr), 32'hFF);
    applyStimulus(0, 0, 0, 0, 8'h00);
    check_ifid("wrap", 8'h00, 8'hFF ^ 8'hA5, 8'h00, 1'b1);
    applyStimulus(0, 0, 0, 0, 8'h00);
    #2 rst = 1'b0;
    #1;
    check_ifid("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("async_ovf", 32'(ras_ovf), 32'd0);
    checkOutput("async_udf", 32'(ras_udf), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'h00);
    check_ifid("post_rst", 8'h01, 8'hA5, 8'h01, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode-stage control unit. It holds the PC, addresses the instruction memory, and latches the fetched word with its PC+1 into IF/ID. It consumes the control unit's B, L and Ret outputs, together with the register-sourced branch target, to redirect fetch. It keeps a small return-address stack (RAS) for branch-to-subroutine and return.

Parameters:
PC_W, 8, PC and address width; the PC wraps modulo 2^PC_W.
INSTR_W, 8, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-4].
RAS_DEPTH, 4, number of return-address entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
stall  in  1  from hazard unit; holds PC, IF/ID and RAS.
B  in  1  branch taken, from the control unit, for the instruction in IF/ID.
L  in  1  branch-to-subroutine, from the control unit.
Ret  in  1  return, from the control unit.
br_target  in  PC_W  branch destination (R[rb]) from the register file.
imem_addr  out  PC_W  instruction memory address; equals pc, combinational.
imem_data  in  INSTR_W  instruction memory read data; asynchronous read of imem_addr.
if_id_instr  out  INSTR_W  latched instruction; drives the control unit opcode.
if_id_pc1  out  PC_W  PC+1 of the latched instruction; this is the link value.
if_id_valid  out  1  IF/ID holds a real fetched instruction.
ras_ovf  out  1  sticky flag: a push occurred while the RAS was full.
ras_udf  out  1  sticky flag: a pop occurred while the RAS was empty.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-operation):
  - pc=0, if_id_instr=0 (NOP), if_id_pc1=0, if_id_valid=0.
  - RAS pointer=0, RAS count=0, RAS entries=0, ras_ovf=0, ras_udf=0.
- Define redirect = B & if_id_valid & ~stall.
- If stall=1: pc, IF/ID, RAS and flags all hold. B, L and Ret are ignored that cycle.
- Normal cycle (stall=0, redirect=0):
  - pc <= pc+1, truncated to PC_W bits (wraps 2^PC_W-1 -> 0).
  - if_id_instr <= imem_data, if_id_pc1 <= pc+1, if_id_valid <= 1.
  - Fetch-to-decode latency is 1 cycle.
- Redirect cycle:
  - pc <= target. target = RAS top if Ret=1, otherwise br_target.
  - IF/ID is flushed: instr=0, valid=0, pc1 holds its previous value.
  - The wrong-path word fetched this cycle is discarded. Redirect penalty is 1 bubble.
- RAS push occurs when redirect & L & ~Ret:
  - entry[ptr] <= if_id_pc1, ptr <= ptr+1 (wraps modulo RAS_DEPTH).
  - count <= min(count+1, RAS_DEPTH).
  - If count==RAS_DEPTH before the push: the oldest entry is overwritten and ras_ovf <= 1.
- RAS pop occurs when redirect & Ret:
  - If count>0: target = entry[ptr-1], ptr <= ptr-1, count <= count-1.
  - If count==0: target = 0, ptr and count unchanged, ras_udf <= 1.
- L and Ret both 1: treated as Ret only, with no push.
- B=0 with L or Ret=1: no action. The control unit guarantees B=1 for these opcodes, so this case only arises from an invalid encoding.
- ras_ovf and ras_udf clear only on reset.
- if_id_valid=0 blocks redirect, so stale branch decode of a bubble has no effect.

Test Plan:
1. Reset then run with imem_data = address XOR 0xA5 -> imem_addr steps 0,1,2,...; one cycle after each address, if_id_instr = that address XOR 0xA5, if_id_pc1 = address+1, valid=1.
2. IF/ID holds the word from pc 0x05; drive B=1, br_target=0x40 -> next edge: imem_addr=0x40, if_id_instr=0, valid=0. Edge after: if_id_instr = mem[0x40], if_id_pc1=0x41.
3. Call at pc 0x10 (B=1, L=1, target 0x80) pushes 0x11. Later Ret with B=1 -> imem_addr=0x11, RAS count back to 0, no flags set.
4. stall=1 for 3 cycles with B=1, br_target=0x33 held -> pc, IF/ID and RAS unchanged throughout. On the first cycle with stall=0, redirect to 0x33 occurs.
5. Five nested calls (link values 0x11,0x21,0x31,0x41,0x51) with RAS_DEPTH=4 -> ras_ovf=1. Four returns yield 0x51,0x41,0x31,0x21 in that order. A fifth return yields target 0 and ras_udf=1.
6. Start with pc=0xFF and no redirect -> pc=0x00. Then pull rst low between edges -> all outputs return to their reset values immediately, before the next clock edge.
